// File: rtl/core_types_pkg.sv
// Shared core sizing constants and PR tag types used by the PRF write-port arbiter.
package core_types_pkg;

  localparam int unsigned PRF_WR_COUNT       = 7;
  localparam int unsigned PRF_BANK_COUNT     = 4;
  localparam int unsigned LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);
  localparam int unsigned LOG_PR_COUNT       = 7;
  localparam int unsigned XLEN               = 32;
  localparam int unsigned LOG_PRF_WR_COUNT   = $clog2(PRF_WR_COUNT);

  typedef logic [LOG_PR_COUNT-1:0]                    pr_t;
  typedef logic [LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] upper_pr_t;
  typedef logic [LOG_PRF_BANK_COUNT-1:0]              bank_t;
  typedef logic [LOG_PRF_WR_COUNT-1:0]                wr_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: grants the first request at or after i_ptr, wrapping modulo REQ_COUNT.
module rr_arbiter #(
  parameter int unsigned REQ_COUNT = 7,
  parameter int unsigned PTR_W     = $clog2(REQ_COUNT)
) (
  input  logic [REQ_COUNT-1:0] i_req,
  input  logic [PTR_W-1:0]     i_ptr,
  output logic [REQ_COUNT-1:0] o_grant,
  output logic [PTR_W-1:0]     o_next_ptr
);

  logic [PTR_W:0] w_idx;
  logic           w_found;

  always_comb begin
    o_grant    = '0;
    o_next_ptr = i_ptr;
    w_found    = 1'b0;
    w_idx      = '0;
    for (int unsigned k = 0; k < REQ_COUNT; k++) begin
      // One extra bit so ptr+k can be folded back below REQ_COUNT with a single subtract.
      w_idx = {1'b0, i_ptr} + (PTR_W+1)'(k);
      if (w_idx >= (PTR_W+1)'(REQ_COUNT)) begin
        w_idx = w_idx - (PTR_W+1)'(REQ_COUNT);
      end
      if (!w_found && i_req[w_idx[PTR_W-1:0]]) begin
        w_found                    = 1'b1;
        o_grant[w_idx[PTR_W-1:0]] = 1'b1;
        o_next_ptr = (w_idx == (PTR_W+1)'(REQ_COUNT-1)) ? '0 : PTR_W'(w_idx + 1'b1);
      end
    end
  end

endmodule

// File: rtl/prf_wr_arbiter.sv
// Per-bank round-robin arbitration of writeback requesters onto registered PRF write ports.
// Optional conflict counters are enabled by defining PRF_WR_ARB_PERF_EN.
module prf_wr_arbiter
  import core_types_pkg::*;
(
  input  logic                                    CLK,
  input  logic                                    RST,
  input  logic      [PRF_WR_COUNT-1:0]            req_valid_by_wr,
  input  pr_t       [PRF_WR_COUNT-1:0]            req_PR_by_wr,
  input  logic      [PRF_WR_COUNT-1:0][XLEN-1:0]  req_data_by_wr,
  output logic      [PRF_WR_COUNT-1:0]            req_ready_by_wr,
  output logic      [PRF_BANK_COUNT-1:0]          prf_wr_valid_by_bank,
  output upper_pr_t [PRF_BANK_COUNT-1:0]          prf_wr_upper_PR_by_bank,
  output logic      [PRF_BANK_COUNT-1:0][XLEN-1:0] prf_wr_data_by_bank,
  output logic      [PRF_BANK_COUNT-1:0]          complete_valid_by_bank,
  output pr_t       [PRF_BANK_COUNT-1:0]          complete_PR_by_bank
`ifdef PRF_WR_ARB_PERF_EN
  ,
  input  logic                                    perf_clear,
  output logic      [PRF_BANK_COUNT-1:0][15:0]    perf_conflict_cnt_by_bank
`endif
);

  logic    [PRF_WR_COUNT-1:0]                     w_pr_zero;
  logic    [PRF_WR_COUNT-1:0]                     w_granted;
  logic    [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0] w_cand;
  logic    [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0] w_grant;
  logic    [PRF_BANK_COUNT-1:0]                   w_bank_gnt;
  wr_idx_t [PRF_BANK_COUNT-1:0]                   w_next_ptr;
  pr_t     [PRF_BANK_COUNT-1:0]                   w_sel_pr;
  logic    [PRF_BANK_COUNT-1:0][XLEN-1:0]         w_sel_data;

  wr_idx_t [PRF_BANK_COUNT-1:0]                   r_rr_ptr;
  logic    [PRF_BANK_COUNT-1:0]                   r_wr_valid;
  pr_t     [PRF_BANK_COUNT-1:0]                   r_pr;
  logic    [PRF_BANK_COUNT-1:0][XLEN-1:0]         r_data;

  // PR0 is hardwired zero: never a bank candidate, acked on sight.
  always_comb begin
    w_pr_zero = '0;
    w_cand    = '0;
    for (int i = 0; i < PRF_WR_COUNT; i++) begin
      w_pr_zero[i] = (req_PR_by_wr[i] == '0);
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        w_cand[b][i] = req_valid_by_wr[i] && !w_pr_zero[i] &&
                       (req_PR_by_wr[i][LOG_PRF_BANK_COUNT-1:0] == bank_t'(b));
      end
    end
  end

  for (genvar g = 0; g < PRF_BANK_COUNT; g++) begin : g_bank
    rr_arbiter #(
      .REQ_COUNT(PRF_WR_COUNT),
      .PTR_W    (LOG_PRF_WR_COUNT)
    ) u_rr_arbiter (
      .i_req     (w_cand[g]),
      .i_ptr     (r_rr_ptr[g]),
      .o_grant   (w_grant[g]),
      .o_next_ptr(w_next_ptr[g])
    );
  end

  always_comb begin
    w_granted  = '0;
    w_bank_gnt = '0;
    w_sel_pr   = '0;
    w_sel_data = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      w_bank_gnt[b] = |w_grant[b];
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
        if (w_grant[b][i]) begin
          w_granted[i]  = 1'b1;
          w_sel_pr[b]   = req_PR_by_wr[i];
          w_sel_data[b] = req_data_by_wr[i];
        end
      end
    end
  end

  assign req_ready_by_wr = {PRF_WR_COUNT{!RST}} & req_valid_by_wr & (w_pr_zero | w_granted);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rr_ptr   <= '0;
      r_wr_valid <= '0;
      r_pr       <= '0;
      r_data     <= '0;
    end else begin
      r_rr_ptr   <= w_next_ptr;
      r_wr_valid <= w_bank_gnt;
      r_pr       <= w_sel_pr;
      r_data     <= w_sel_data;
    end
  end

  always_comb begin
    prf_wr_upper_PR_by_bank = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      prf_wr_upper_PR_by_bank[b] = r_pr[b][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
    end
  end

  assign prf_wr_valid_by_bank   = r_wr_valid;
  assign prf_wr_data_by_bank    = r_data;
  assign complete_valid_by_bank = r_wr_valid;
  assign complete_PR_by_bank    = r_pr;

`ifdef PRF_WR_ARB_PERF_EN
  logic [PRF_BANK_COUNT-1:0][15:0] r_perf_cnt;
  logic [PRF_BANK_COUNT-1:0]       w_conflict;

  always_comb begin
    w_conflict = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      w_conflict[b] = ($countones(w_cand[b]) > 1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_perf_cnt <= '0;
    end else begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        if (perf_clear) begin
          r_perf_cnt[b] <= '0;
        end else if (w_conflict[b] && (r_perf_cnt[b] != 16'hFFFF)) begin
          r_perf_cnt[b] <= r_perf_cnt[b] + 16'd1;
        end
      end
    end
  end

  assign perf_conflict_cnt_by_bank = r_perf_cnt;
`else
  // Conflict counters compiled out; arbitration is unaffected.
`endif

endmodule

// File: doc/prf_wr_arbiter.md
Name: prf_wr_arbiter

Overview:
- Shares the physical register file's per-bank write ports among all writeback requesters (ALU, MDU, LDU, BRU, SYS pipes).
- PR bank = PR[LOG_PRF_BANK_COUNT-1:0]; each bank accepts one write per cycle.
- Arbitrates per bank with round-robin fairness, handshakes losers back, and drives registered bank write ports.

Parameters:
- PRF_WR_COUNT, 7, number of writeback requesters.
- PRF_BANK_COUNT, 4, number of PRF banks (power of 2).
- LOG_PR_COUNT, 7, PR tag width.
- XLEN, 32, write data width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- req_valid_by_wr  in  PRF_WR_COUNT  writeback request valid.
- req_PR_by_wr  in  PRF_WR_COUNT x LOG_PR_COUNT  destination PR.
- req_data_by_wr  in  PRF_WR_COUNT x XLEN  write data.
- req_ready_by_wr  out  PRF_WR_COUNT  combinational grant; a transfer occurs when valid && ready.
- prf_wr_valid_by_bank  out  PRF_BANK_COUNT  registered bank write enable.
- prf_wr_upper_PR_by_bank  out  PRF_BANK_COUNT x (LOG_PR_COUNT-LOG_PRF_BANK_COUNT)  registered row index within bank.
- prf_wr_data_by_bank  out  PRF_BANK_COUNT x XLEN  registered write data.
- complete_valid_by_bank  out  PRF_BANK_COUNT  registered wakeup broadcast, same cycle as the bank write.
- complete_PR_by_bank  out  PRF_BANK_COUNT x LOG_PR_COUNT  full PR for the wakeup.

Behaviour:
- Reset (async, any time): all registered outputs 0; all RR pointers 0; ready deasserts combinationally while RST is high. An in-flight registered write is discarded.
- Per bank b, the candidate set is the requesters with valid && PR bank == b && PR != 0.
- Winner: the first candidate at or after rr_ptr[b], scanning upward modulo PRF_WR_COUNT (wraps 6->0).
- On a grant, rr_ptr[b] <= winner+1 mod PRF_WR_COUNT. With no candidate, rr_ptr[b] holds.
- req_ready = 1 for each per-bank winner. Non-winners get ready = 0 and must hold valid/PR/data stable until granted.
- PR == 0 is a hardwired-zero register: ready = 1 immediately, no bank write, no complete broadcast, and no effect on any pointer.
- Latency: a grant in cycle N produces bank write and complete outputs in cycle N+1. Outputs are valid for exactly one cycle per grant.
- Up to PRF_BANK_COUNT grants per cycle (one per bank), plus any number of PR0 drops.
- Ready is combinational from valid/PR/pointers, with no dependency on outputs. Requesters must not make valid depend on ready.
- Full throughput: a requester granted every cycle sustains 1 write/cycle if uncontested.

Optional Feature:
- Macro: PRF_WR_ARB_PERF_EN.
- Enabled:
  - Adds output perf_conflict_cnt_by_bank (PRF_BANK_COUNT x 16).
  - Each counter increments by 1 each cycle its bank has at least 2 candidates; it saturates at 16'hFFFF and resets to 0.
  - Adds input perf_clear: synchronous clear of all counters; clear wins over increment.
- Disabled: the port and counter logic are absent; arbitration is identical.

Decomposition:
- Shared package (core_types_pkg) holds PRF_BANK_COUNT, LOG_PRF_BANK_COUNT, PRF_WR_COUNT, LOG_PR_COUNT, XLEN.
- Add typedef pr_t = logic [LOG_PR_COUNT-1:0] and upper_pr_t to the package.
- One natural sub-module: rr_arbiter (REQ_COUNT parameter; inputs req vector and ptr; outputs one-hot grant and next ptr). Instantiate it once per bank.

Test Plan:
- Reset:
  - Stimulus: assert RST mid-stream with req 0 valid to PR 5.
  - Response: ready=0 while RST is high; outputs 0 immediately. After release, a grant to PR5 gives bank1 write, upper_PR=1, one cycle later.
- Parallel banks:
  - Stimulus: req0 PR4, req1 PR5, req2 PR6, req3 PR7 all valid.
  - Response: all ready in the same cycle; next cycle banks 0-3 write rows 1/1/1/1 with the correct data and complete PRs 4-7.
- Round-robin:
  - Stimulus: all 7 requesters target bank 2, each held until granted.
  - Response: grants 0,1,2,3,4,5,6 on consecutive cycles; pointer wraps to 0 after requester 6.
- Conflict hold:
  - Stimulus: req3 and req5 both target PR 9, with rr_ptr[1]=4.
  - Response: req5 granted first, then req3 next cycle with unchanged data written.
- PR0 drop:
  - Stimulus: req2 valid with PR0 alongside req2-competing traffic.
  - Response: req2 ready the same cycle; no bank write, no complete, pointers unchanged.
- Perf (PRF_WR_ARB_PERF_EN):
  - Stimulus: 3 cycles of a 2-way bank-0 conflict, then perf_clear concurrent with a conflict.
  - Response: counter reads 3, then 0.
